// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample pair handshake between the apu sample generator and the I2S serializer
interface i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [2*SAMPLE_WIDTH-1:0] sample_in;
  logic                      sample_valid;
  logic                      sample_ready;
  modport master(output sample_in, sample_valid, input sample_ready);
  modport slave(input sample_in, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: stereo PCM to I2S serializer with programmable bit clock and single-entry sample buffer
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_HALF    = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    enable,
  i2s_tx_if.slave s,
  output logic    bit_clk,
  output logic    frame_clk,
  output logic    sdata,
  output logic    underrun
);
  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int DW = $clog2(BCLK_HALF);
  localparam int PW = $clog2(FW);
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] pos, pos_nxt;
  logic [FW-1:0] sample_buf, sr;
  logic          full, started, wrap, fall, fs, accept;
  assign s.sample_ready = enable & ~full;
  // started distinguishes the very first falling event after idle, which opens a frame without advancing pos
  always_comb begin
    wrap    = div_cnt == DW'(BCLK_HALF - 1);
    fall    = enable & wrap & bit_clk;
    fs      = fall & (~started | pos == PW'(FW - 1));
    pos_nxt = fs ? '0 : pos + 1'b1;
    accept  = s.sample_valid & s.sample_ready;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_buf <= '0;
      full       <= 1'b0;
      underrun   <= 1'b0;
      div_cnt    <= '0;
      pos        <= '0;
      sr         <= '0;
      started    <= 1'b0;
      bit_clk    <= 1'b0;
      frame_clk  <= 1'b0;
      sdata      <= 1'b0;
    end else begin
      if (accept) begin
        sample_buf <= s.sample_in;
        full       <= 1'b1;
      end else if (fs) begin
        full <= 1'b0;
      end
      underrun <= fs & ~full;
      if (!enable) begin
        div_cnt   <= '0;
        pos       <= '0;
        sr        <= '0;
        started   <= 1'b0;
        bit_clk   <= 1'b0;
        frame_clk <= 1'b0;
        sdata     <= 1'b0;
      end else begin
        div_cnt <= wrap ? '0 : div_cnt + 1'b1;
        if (wrap) bit_clk <= ~bit_clk;
        // sdata lags the shift register by one bclk, giving the I2S one-bit delay
        if (fall) begin
          started   <= 1'b1;
          pos       <= pos_nxt;
          frame_clk <= pos_nxt >= PW'(SAMPLE_WIDTH);
          sdata     <= sr[FW-1];
          sr        <= fs ? (full ? sample_buf : '0) : sr << 1;
        end
      end
    end
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serializes stereo PCM sample pairs into an I2S stream (bit_clk, frame_clk, sdata) for the external audio codec.
- Sits directly downstream of the apu sample generator, which supplies one left/right pair per frame over a valid/ready handshake.
- Derives bit_clk from the chip clock by a programmable divider.
- Holds a single-entry buffer and reports underruns.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel. Frame length is 2*SAMPLE_WIDTH bit_clk periods, with no padding slots.
- BCLK_HALF, 4: clk cycles per bit_clk half-period. Must be >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- enable  input  1  run the serializer. Low holds the outputs idle.
- sample_in  input  2*SAMPLE_WIDTH  {left, right}, two's complement, left in the upper half.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  buffer can accept a pair.
- bit_clk  output  1  I2S serial clock.
- frame_clk  output  1  I2S word select. 0 = left, 1 = right.
- sdata  output  1  I2S serial data, MSB first.
- underrun  output  1  one-clk pulse when a frame starts with an empty buffer.

Behaviour:
- Reset asserted (async): bit_clk=0, frame_clk=0, sdata=0, underrun=0. Buffer empty, shift register 0, divider and bit position 0.
- sample_ready = enable & ~buffer_full. This is combinational from registered state, so it is 1 after reset when enable=1.
- Accept: sample_valid & sample_ready on a rising clk edge. The pair is written to the buffer and buffer_full is set.
- Divider: div_cnt counts 0..BCLK_HALF-1. bit_clk toggles on the cycle div_cnt wraps.
  - bit_clk period = 2*BCLK_HALF clk.
  - All output updates happen on the clk cycle in which bit_clk goes 1->0 (the falling event), so the codec samples stable data on the rising edge.
- Bit position pos counts 0..2*SAMPLE_WIDTH-1 and advances on each falling event, wrapping to 0.
- frame_clk = 0 for pos < SAMPLE_WIDTH, else 1.
- Frame start, at the falling event that enters pos=0:
  - Buffer full: the pair moves into the shift register and buffer_full clears in the same cycle.
  - Buffer empty: the shift register loads 0 and underrun pulses high for exactly this one clk.
- Data has a one-bclk I2S delay. sdata at pos p carries stream bit p-1, where the stream is {L[MSB..0], R[MSB..0]}.
  - pos=0 carries R[0] of the previous frame.
  - Left MSB appears at pos=1.
  - L[0] appears at pos=SAMPLE_WIDTH, together with frame_clk rising.
  - Right MSB appears at pos=SAMPLE_WIDTH+1.
- Simultaneous events:
  - Frame start with an empty buffer and an accept in the same cycle: underrun fires and zeros are loaded. The accepted pair stays in the buffer for the next frame.
  - With the buffer full, sample_ready=0, so no accept can coincide with a load. sample_ready rises the cycle after the load.
- Enable low, sampled synchronously:
  - Next cycle: bit_clk=0, frame_clk=0, sdata=0, div_cnt=0, pos=0, and the shift register and delay flop are cleared.
  - Buffer contents are retained.
  - After enable returns high: first bit_clk rise after BCLK_HALF clk, first falling event (frame start, pos=0) after 2*BCLK_HALF clk.
  - Mid-frame drop: the partial frame is discarded and no underrun is signalled.
- Async reset mid-frame: all state clears immediately and the stream restarts as after the enable rule.

Test Plan:
- Reset/idle: reset=0, then release with enable=1 and no samples. All outputs 0 and sample_ready=1 before the first frame start. bit_clk first rises 4 clk after release and has a period of 8 clk.
- Single pair: load 32'hA5F0_0F0F before enabling.
  - frame_clk low for 16 bclk, then high for 16 bclk.
  - sdata sampled on bit_clk rises at pos 1..16 = A5F0 MSB-first.
  - pos 17..31 plus next pos 0 = 0F0F.
  - sdata at pos 0 of the first frame = 0.
- Underrun: supply one pair only.
  - underrun pulses for 1 clk at the second frame start and not at the first.
  - sdata is 0 throughout the second frame except at pos 0, which carries R[0]=1 of the first pair.
- Backpressure: hold sample_valid=1 with incrementing data.
  - sample_ready stays 0 while the buffer is full and rises 1 clk after each frame start.
  - Exactly one pair is consumed per 256 clk (SAMPLE_WIDTH=16, BCLK_HALF=4).
  - No pair is skipped or duplicated.
- Coincident accept: assert valid for first time exactly on frame-start cycle with buffer empty -> underrun=1 that cycle, pair appears in following frame.
- Enable/reset mid-frame: drop enable at pos=10 for 20 clk -> outputs 0 next cycle, restart at pos=0 after 8 clk, buffered pair preserved; repeat with reset pulse -> outputs 0 immediately, buffer empty.
